// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
//   The bundle of signals that the two requesters, the arbiter and the data
//   memory use to talk to each other.
//
//   Handshake: a requester raises *_req with *_we/*_addr/*_wdata and keeps
//   all four unchanged until it sees *_gnt high in the same cycle. The access
//   is performed at the rising edge that ends that cycle. A granted read
//   (we == 4'b0000) returns exactly one *_rvalid pulse with *_rdata in the
//   cycle after the grant. A granted write returns nothing.
//
//   Modports:
//     slave  - the arbiter: requests and mem_rdata in, grants/responses/
//              memory controls/starved out.
//     master - the environment: requesters plus memory.
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 14
);
    // CPU memory-stage requester
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;

    // Debug / bootloader requester
    logic          dbg_req;
    logic [3:0]    dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [31:0]   dbg_rdata;

    // Data memory port
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Status
    logic          starved;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output starved
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  starved
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port (sync block RAM, 4 byte enables,
//   1-cycle read latency) between the CPU memory stage and the debug/loader
//   port. The CPU has priority; a starvation counter forces a debug grant
//   after STARVE_LIMIT consecutive denied debug cycles. Each read response
//   is routed back to the requester that issued it.
//
//   Ports:
//     clk    - system clock, all state on the rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - dmem_arbiter_if.slave: cpu_*, dbg_*, mem_*, starved
//
//   Parameters:
//     AW           - word-address width of dmem
//     STARVE_LIMIT - denied debug cycles before a forced grant (1..255)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW           = 14,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]    starve_cnt;
    logic [7:0]    starve_nxt;
    logic          force_q;    // debug has priority this cycle
    logic          rd_pend;    // a read was granted last cycle
    logic          rd_owner;   // 0 = CPU, 1 = debug

    logic          cpu_win;    // grant before reset gating
    logic          dbg_win;
    logic          cpu_rd;
    logic          dbg_rd;
    logic [AW-1:0] addr_sel;

    // ------------------------------------------------------------------
    // Arbitration. The state only decides which side has priority; the
    // grants themselves follow the live requests so that a requester is
    // accepted in the same cycle it asks.
    // ------------------------------------------------------------------
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (force_q) begin
            dbg_win = bus.dbg_req;
            cpu_win = bus.cpu_req & ~bus.dbg_req;
        end else begin
            cpu_win = bus.cpu_req;
            dbg_win = bus.dbg_req & ~bus.cpu_req;
        end
    end

    // The registers are all in reset while rst_n is low, but the requests are
    // not, so the visible grants are masked directly by rst_n. The internal
    // next-state logic uses the unmasked versions; their values are
    // irrelevant while the flops are held in reset.
    assign bus.cpu_gnt = rst_n & cpu_win;
    assign bus.dbg_gnt = rst_n & dbg_win;

    assign cpu_rd = cpu_win & (bus.cpu_we == 4'b0000);
    assign dbg_rd = dbg_win & (bus.dbg_we == 4'b0000);

    // ------------------------------------------------------------------
    // Memory mux. With no grant, address/data idle on the CPU inputs.
    // ------------------------------------------------------------------
    assign addr_sel      = dbg_win ? bus.dbg_addr : bus.cpu_addr;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_en    = bus.cpu_gnt | bus.dbg_gnt;

    always_comb begin
        bus.mem_we = 4'b0000;
        if (bus.cpu_gnt) begin
            bus.mem_we = bus.cpu_we;
        end else if (bus.dbg_gnt) begin
            bus.mem_we = bus.dbg_we;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive denied debug cycles and
    // saturates at 255 so a very large limit never wraps back to zero.
    // ------------------------------------------------------------------
    always_comb begin
        starve_nxt = 8'd0;
        if (bus.dbg_req & ~dbg_win) begin
            starve_nxt = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
            force_q    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;

            // Force takes effect in the cycle right after the count reaches
            // the limit. It is dropped once debug has been served or has
            // given up, so the CPU loses at most one cycle per forced grant.
            if (dbg_win | ~bus.dbg_req) begin
                force_q <= 1'b0;
            end else if (starve_nxt >= LIMIT) begin
                force_q <= 1'b1;
            end

            rd_pend <= cpu_rd | dbg_rd;
            if (cpu_rd | dbg_rd) begin
                rd_owner <= dbg_rd;
            end
        end
    end

    assign bus.starved = force_q;

    // ------------------------------------------------------------------
    // Read response: memory data is valid in the cycle after the grant and
    // only the owner sees it; the other side reads zero.
    // ------------------------------------------------------------------
    assign bus.cpu_rvalid = rd_pend & ~rd_owner;
    assign bus.dbg_rvalid = rd_pend &  rd_owner;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'h0;

endmodule
